// File: rtl/fu_arb_pkg.sv
// Shared types for the float-unit arbiter: requester id width, tag record, one-hot decode.
// Purely declarative; no latency and no backpressure of its own.
package fu_arb_pkg;

    localparam int FU_NUM_REQ = 4;
    localparam int ID_W       = (FU_NUM_REQ > 1) ? $clog2(FU_NUM_REQ) : 1;

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
    } fu_tag_t;

    function automatic logic [FU_NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        logic [FU_NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/float_unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo NUM_REQ.
// Zero latency; applies no backpressure, the caller decides whether the grant is taken.
module rr_arbiter
    import fu_arb_pkg::*;
#(
    parameter int NUM_REQ = FU_NUM_REQ,
    parameter int ID_W_P  = ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W_P-1:0]  ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W_P-1:0]  grant_id,
    output logic               any
);

    logic              w_found;
    logic [ID_W_P-1:0] w_idx;

    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W_P'((int'(ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found         = 1'b1;
                grant_oh[w_idx] = 1'b1;
                grant_id        = w_idx;
            end
        end
        any = w_found;
    end

endmodule

// File: rtl/float_unit_arbiter.sv
// Round-robin share of one fixed-latency float unit; FUARB_STATS_EN adds issue/stall counters.
// Result returns LATENCY+1 cycles after accept; responses cannot be stalled, req_ready is the only throttle.
module float_unit_arbiter
    import fu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = FU_NUM_REQ,
    parameter int LATENCY    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [DATA_WIDTH-1:0]         unit_in,
    input  logic [DATA_WIDTH-1:0]         unit_out,
    output logic                          busy
`ifdef FUARB_STATS_EN
    ,
    output logic [31:0]                   issue_cnt,
    output logic [31:0]                   stall_cnt
`endif
);

    logic [NUM_REQ-1:0]    w_grant_oh;
    logic [ID_W-1:0]       w_grant_id;
    logic                  w_any;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [ID_W-1:0]       w_ptr_nxt;
    logic                  w_busy;

    logic [ID_W-1:0]       r_ptr;
    logic [DATA_WIDTH-1:0] r_unit_in;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    // tag[0] rides alongside unit_in, so tag[LATENCY] lines up with unit_out.
    fu_tag_t               r_tag [LATENCY+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W_P  (ID_W)
    ) u_rr (
        .req      (req_valid),
        .ptr      (r_ptr),
        .grant_oh (w_grant_oh),
        .grant_id (w_grant_id),
        .any      (w_any)
    );

    assign req_ready = rst ? '0 : w_grant_oh;
    assign w_accept  = w_any & ~rst;
    assign w_ptr_nxt = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_unit_in   <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_unit_in <= w_sel_data;
                r_ptr     <= w_ptr_nxt;
            end
            r_tag[0].v  <= w_accept;
            r_tag[0].id <= w_grant_id;
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
            // unit_out is only trusted when a live tag reaches the tail.
            if (r_tag[LATENCY].v) begin
                r_rsp_data  <= unit_out;
                r_rsp_valid <= NUM_REQ'(onehot(r_tag[LATENCY].id));
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    always_comb begin
        w_busy = |r_rsp_valid;
        for (int k = 0; k <= LATENCY; k++) begin
            w_busy = w_busy | r_tag[k].v;
        end
    end

    assign unit_in   = r_unit_in;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign busy      = w_busy;

`ifdef FUARB_STATS_EN
    logic        w_stall;
    logic [31:0] r_issue_cnt;
    logic [31:0] r_stall_cnt;

    assign w_stall = ($countones(req_valid) > 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && (r_issue_cnt != '1)) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign issue_cnt = r_issue_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_float_unit_arbiter.sv
// Directed bench for float_unit_arbiter against a LATENCY-deep x+1.0 unit model.
// Honours FUARB_STATS_EN by also checking the issue/stall counters.
module tb_float_unit_arbiter;

    localparam int LAT = 5;
    localparam int NR  = 4;
    localparam int NROWS = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*32-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [31:0]       rsp_data;
    logic [31:0]       unit_in;
    logic [31:0]       unit_out;
    logic              busy;
`ifdef FUARB_STATS_EN
    logic [31:0]       issue_cnt;
    logic [31:0]       stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    float_unit_arbiter #(
        .DATA_WIDTH (32),
        .NUM_REQ    (NR),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .unit_in   (unit_in),
        .unit_out  (unit_out),
        .busy      (busy)
`ifdef FUARB_STATS_EN
        ,
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // x + 1.0 for the small set of operands the bench uses
    function automatic logic [31:0] f_plus1(input logic [31:0] x);
        case (x)
            32'h3F800000: return 32'h40000000;
            32'h40000000: return 32'h40400000;
            32'h40400000: return 32'h40800000;
            32'h40800000: return 32'h40A00000;
            32'h40A00000: return 32'h40C00000;
            default:      return 32'hDEAD0000;
        endcase
    endfunction

    logic [31:0] m_pipe [LAT];
    always @(posedge clk) begin
        m_pipe[0] <= f_plus1(unit_in);
        for (int k = 1; k < LAT; k++) begin
            m_pipe[k] <= m_pipe[k-1];
        end
    end
    assign unit_out = m_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  ready;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        busy;
    } vec_t;

    vec_t        tbl [NROWS];
    logic [31:0] exp_res [4];
    logic [3:0]  exp5 [3];

    initial begin
        // results of (i+1.0)+1.0 for requester i
        exp_res[0] = 32'h40000000;
        exp_res[1] = 32'h40400000;
        exp_res[2] = 32'h40800000;
        exp_res[3] = 32'h40A00000;

        for (int r = 0; r < NROWS; r++) begin
            tbl[r] = '{valid: 4'b0000, ready: 4'b0000, rv: 4'b0000, rd: 32'h0, busy: 1'b0};
        end
        // all four valid: strict rotation, results 7 rows later
        for (int r = 0; r < 8; r++) begin
            tbl[r].valid = 4'b1111;
            tbl[r].ready = 4'b0001 << (r % 4);
        end
        for (int r = 7; r < 15; r++) begin
            tbl[r].rv = 4'b0001 << ((r - 7) % 4);
            tbl[r].rd = exp_res[(r - 7) % 4];
        end
        // req2 alone, back to back
        for (int r = 15; r < 21; r++) begin
            tbl[r].valid = 4'b0100;
            tbl[r].ready = 4'b0100;
        end
        for (int r = 22; r < 28; r++) begin
            tbl[r].rv = 4'b0100;
            tbl[r].rd = exp_res[2];
        end
        // ptr=3 then wrap; lower index beats higher below ptr
        tbl[21].valid = 4'b1001; tbl[21].ready = 4'b1000;
        tbl[22].valid = 4'b1001; tbl[22].ready = 4'b0001;
        tbl[23].valid = 4'b0001; tbl[23].ready = 4'b0001;
        tbl[24].valid = 4'b0101; tbl[24].ready = 4'b0100;
        tbl[28].rv = 4'b1000; tbl[28].rd = exp_res[3];
        tbl[29].rv = 4'b0001; tbl[29].rd = exp_res[0];
        tbl[30].rv = 4'b0001; tbl[30].rd = exp_res[0];
        tbl[31].rv = 4'b0100; tbl[31].rd = exp_res[2];
        for (int r = 1; r < 15; r++)  tbl[r].busy = 1'b1;
        for (int r = 16; r < 32; r++) tbl[r].busy = 1'b1;

        exp5[0] = 4'b0010;
        exp5[1] = 4'b0100;
        exp5[2] = 4'b0001;

        // reset state, with requests pending to show ready is held low
        rst       = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) begin
            req_data[i*32 +: 32] = 32'h3F800000 + (32'h00800000 * i);
        end
        req_data[0 +: 32] = 32'h3F800000;
        req_data[32 +: 32] = 32'h40000000;
        req_data[64 +: 32] = 32'h40400000;
        req_data[96 +: 32] = 32'h40800000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset ready", 32'(req_ready), 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_data", rsp_data, 32'h0);
        chk("reset unit_in", unit_in, 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
`ifdef FUARB_STATS_EN
        chk("reset issue_cnt", issue_cnt, 32'h0);
        chk("reset stall_cnt", stall_cnt, 32'h0);
`endif
        rst       = 1'b0;
        req_valid = 4'b0000;

        // table-driven rows
        for (int r = 0; r < NROWS; r++) begin
            @(negedge clk);
            req_valid = tbl[r].valid;
            #1;
            chk($sformatf("row%0d ready", r), 32'(req_ready), 32'(tbl[r].ready));
            chk($sformatf("row%0d rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].rv));
            chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].busy));
            if (tbl[r].rv != 4'b0000) begin
                chk($sformatf("row%0d rsp_data", r), rsp_data, tbl[r].rd);
            end
`ifdef FUARB_STATS_EN
            if (r == 8) begin
                chk("issue_cnt after rotation", issue_cnt, 32'd8);
                chk("stall_cnt after rotation", stall_cnt, 32'd8);
            end
`endif
        end

        // single op from req0, 3.0 -> 4.0, result exactly LAT+1 edges after accept
        req_data[0 +: 32] = 32'h40400000;
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        chk("single ready", 32'(req_ready), 32'h1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            req_valid = 4'b0000;
            #1;
            chk($sformatf("single n%0d rsp_valid", n), 32'(rsp_valid), (n == LAT + 1) ? 32'h1 : 32'h0);
            if (n == LAT + 1) begin
                chk("single rsp_data", rsp_data, 32'h40800000);
            end
        end

        // three ops in flight (ptr=1 -> grants 1,2,0), then reset discards them
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 4'b0111;
            #1;
            chk($sformatf("flush issue%0d ready", c), 32'(req_ready), 32'(exp5[c]));
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("ready during rst", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0011;
        #1;
        chk("post-rst busy", 32'(busy), 32'h0);
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("post-rst ptr0 grant", 32'(req_ready), 32'h1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            req_valid = 4'b0000;
            #1;
            chk($sformatf("post-rst n%0d rsp_valid", n), 32'(rsp_valid), (n == LAT + 1) ? 32'h1 : 32'h0);
            if (n == LAT + 1) begin
                chk("post-rst rsp_data", rsp_data, 32'h40800000);
            end
        end
        chk("final busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
